mem_port_arbiter: RTL and testbench

- Shares a single unified memory port between instruction fetch (IF requester) and the data access of the MEM stage (DM requester).
- Data has fixed priority, with an anti-starvation cap for fetch.
- Each granted access is sequenced over a req/ack memory handshake of variable latency.
- Produces per-requester stall signals, used by the hazard logic to freeze the pipeline registers, including the MEM stage register.

---
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory port between instruction fetch (IF) and MEM-stage data
// access (DM). Data requests win by default. After MAX_D_BURST back-to-back
// data grants made while a fetch was waiting, the next grant goes to fetch.
// Each grant runs one req/ack memory transaction. A transaction that gets no
// ack within TIMEOUT cycles is aborted, and the sticky err flag is set.
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   if_req/if_addr                   fetch request (held until if_done)
//   if_rdata/if_done/if_stall        fetch result, 1-cycle done, stall
//   dm_req/dm_we/dm_addr/dm_wdata    data request (held until dm_done)
//   dm_rdata/dm_done/dm_stall        load result, 1-cycle done, stall
//   mem_req/mem_we/mem_addr/mem_wdata  registered memory request
//   mem_rdata/mem_ack                memory response
//   err                              sticky timeout flag

module mem_port_arbiter #(
    parameter int MAX_D_BURST = 4,
    parameter int TIMEOUT     = 64,
    parameter int CNT_W       = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    output logic        if_stall,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_done,
    output logic        dm_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        err
);

    localparam int SW = $clog2(MAX_D_BURST + 1);
    localparam logic [SW-1:0]    D_MAX  = SW'(MAX_D_BURST);
    localparam logic [CNT_W-1:0] T_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t           state, state_nxt;
    logic             grant_dm_q;
    logic [CNT_W-1:0] tmo_cnt;
    logic [SW-1:0]    d_streak;

    logic cap_hit, grant_if, grant_dm, ack_hit, tmo_hit;

    // Grant decode and next state. Arbitration is evaluated only in IDLE.
    // mem_req is high exactly while in BUSY, so mem_ack is considered only there.
    always_comb begin
        cap_hit   = (d_streak == D_MAX);
        grant_if  = 1'b0;
        grant_dm  = 1'b0;
        ack_hit   = 1'b0;
        tmo_hit   = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                grant_if = if_req & (cap_hit | ~dm_req);
                grant_dm = dm_req & ~(if_req & cap_hit);
                if (grant_if | grant_dm)
                    state_nxt = BUSY;
            end
            BUSY: begin
                ack_hit = mem_ack;
                tmo_hit = ~mem_ack & (tmo_cnt == T_LAST);
                if (ack_hit | tmo_hit)
                    state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Memory request, response capture and bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            if_done    <= 1'b0;
            dm_done    <= 1'b0;
            err        <= 1'b0;
            grant_dm_q <= 1'b0;
            tmo_cnt    <= '0;
            d_streak   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_if | grant_dm) begin
                        mem_req    <= 1'b1;
                        mem_we     <= grant_dm & dm_we;
                        mem_addr   <= grant_dm ? dm_addr : if_addr;
                        mem_wdata  <= grant_dm ? dm_wdata : 32'h0000_0000;
                        grant_dm_q <= grant_dm;
                        tmo_cnt    <= '0;
                        // Only data grants that made a fetch wait count toward the cap.
                        if (grant_dm && if_req) begin
                            if (!cap_hit)
                                d_streak <= d_streak + SW'(1);
                        end else begin
                            d_streak <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (ack_hit || tmo_hit) begin
                        mem_req <= 1'b0;
                        if (tmo_hit)
                            err <= 1'b1;
                        if (grant_dm_q) begin
                            dm_done <= 1'b1;
                            // A store leaves the last load value in place.
                            if (!mem_we)
                                dm_rdata <= ack_hit ? mem_rdata : 32'h0000_0000;
                        end else begin
                            if_done  <= 1'b1;
                            if_rdata <= ack_hit ? mem_rdata : 32'h0000_0000;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if_done <= 1'b0;
                    dm_done <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign if_stall = if_req & ~if_done;
    assign dm_stall = dm_req & ~dm_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        if_stall;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic        dm_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        err;

    int errors = 0;
    int checks = 0;

    // memory responder settings
    int          mem_lat  = 0;
    bit          mem_hang = 0;
    logic [31:0] mem_data = 32'h0;
    int          busy_cnt = 0;

    mem_port_arbiter #(.MAX_D_BURST(4), .TIMEOUT(64), .CNT_W(7)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_done(if_done), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .err(err)
    );

    always #5 clk = ~clk;

    // Memory model: acks in the (mem_lat+1)-th cycle that mem_req is high.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                busy_cnt++;
                if (!mem_hang && busy_cnt > mem_lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_data;
                end else begin
                    mem_ack   = 1'b0;
                end
            end else begin
                busy_cnt = 0;
                mem_ack  = 1'b0;
            end
        end
    end

    // Returns the number of negedges until the selected done is seen, -1 if never.
    task automatic wait_done(input bit dm, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (dm ? dm_done : if_done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_req, mem_we, if_done, dm_done, err, if_stall, dm_stall} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 0000000",
                     {mem_req, mem_we, if_done, dm_done, err, if_stall, dm_stall});
        end
        checks++;
        if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'h0) begin
            errors++;
            $display("FAIL reset_data: got %h required 0", {mem_addr, mem_wdata, if_rdata, dm_rdata});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_load();
        int n;
        mem_lat = 3; mem_data = 32'hCAFE_BABE;
        dm_req = 1; dm_we = 0; dm_addr = 32'h100;
        @(negedge clk);
        checks++;
        if ({mem_req, mem_we, mem_addr, dm_stall} !== {1'b1, 1'b0, 32'h100, 1'b1}) begin
            errors++;
            $display("FAIL load_grant: req=%b we=%b addr=%h stall=%b required 1 0 00000100 1",
                     mem_req, mem_we, mem_addr, dm_stall);
        end
        wait_done(1, 100, n);
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL load_latency: got %0d required 4", n);
        end
        checks++;
        if ({dm_rdata, dm_stall, if_done} !== {32'hCAFE_BABE, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL load_done: rdata=%h stall=%b if_done=%b required cafebabe 0 0",
                     dm_rdata, dm_stall, if_done);
        end
        dm_req = 0;
        @(negedge clk);
        checks++;
        if (dm_done !== 1'b0) begin
            errors++;
            $display("FAIL load_done_width: dm_done=%b required 0", dm_done);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_wait_fetch();
        mem_lat = 0; mem_data = 32'hA5A5_0004;
        if_req = 1; if_addr = 32'h4;
        @(negedge clk);
        checks++;
        if ({mem_req, mem_we, mem_addr, if_stall, if_done} !== {1'b1, 1'b0, 32'h4, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL fetch_grant: req=%b we=%b addr=%h stall=%b done=%b required 1 0 00000004 1 0",
                     mem_req, mem_we, mem_addr, if_stall, if_done);
        end
        @(negedge clk);
        checks++;
        if ({if_done, if_stall, mem_req, dm_done, if_rdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'hA5A5_0004}) begin
            errors++;
            $display("FAIL fetch_done: done=%b stall=%b mem_req=%b dm_done=%b rdata=%h required 1 0 0 0 a5a50004",
                     if_done, if_stall, mem_req, dm_done, if_rdata);
        end
        if_req = 0;
        @(negedge clk);
        checks++;
        if ({if_done, mem_req} !== 2'b00) begin
            errors++;
            $display("FAIL fetch_after: done=%b mem_req=%b required 0 0", if_done, mem_req);
        end
    endtask

    task automatic test_priority();
        int exp_dm[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        int k = 0;
        mem_lat = 0; mem_data = 32'h5555_AAAA;
        if_req = 1; if_addr = 32'h40;
        dm_req = 1; dm_we = 0; dm_addr = 32'h500;
        for (int c = 0; c < 60 && k < 10; c++) begin
            @(negedge clk);
            if (if_done && dm_done) begin
                checks++; errors++;
                $display("FAIL both_done: if_done=1 dm_done=1 required at most one");
            end else if (if_done || dm_done) begin
                checks++;
                if (int'(dm_done) !== exp_dm[k]) begin
                    errors++;
                    $display("FAIL grant_order[%0d]: got dm=%0d required dm=%0d", k, dm_done, exp_dm[k]);
                end
                k++;
            end
        end
        if_req = 0; dm_req = 0;
        checks++;
        if (k !== 10) begin
            errors++;
            $display("FAIL grant_count: got %0d required 10", k);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_store();
        int n;
        mem_lat = 1; mem_data = 32'hDEAD_BEEF;
        dm_req = 1; dm_we = 1; dm_addr = 32'h200; dm_wdata = 32'h1234_5678;
        @(negedge clk);
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h200, 32'h1234_5678}) begin
            errors++;
            $display("FAIL store_grant: req=%b we=%b addr=%h wdata=%h required 1 1 00000200 12345678",
                     mem_req, mem_we, mem_addr, mem_wdata);
        end
        wait_done(1, 20, n);
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL store_latency: got %0d required 2", n);
        end
        checks++;
        if (dm_rdata !== 32'h5555_AAAA) begin
            errors++;
            $display("FAIL store_rdata_hold: got %h required 5555aaaa", dm_rdata);
        end
        dm_req = 0; dm_we = 0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int n;
        mem_hang = 1;
        dm_req = 1; dm_we = 0; dm_addr = 32'h300;
        wait_done(1, 200, n);
        checks++;
        if (n !== 65) begin
            errors++;
            $display("FAIL timeout_latency: got %0d required 65", n);
        end
        checks++;
        if ({dm_rdata, err, mem_req} !== {32'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL timeout_result: rdata=%h err=%b mem_req=%b required 00000000 1 0",
                     dm_rdata, err, mem_req);
        end
        dm_req = 0;
        mem_hang = 0; mem_lat = 0; mem_data = 32'h1111_2222;
        @(negedge clk);
        @(negedge clk);
        dm_req = 1; dm_addr = 32'h304;
        wait_done(1, 20, n);
        checks++;
        if ({n == 2, dm_rdata, err} !== {1'b1, 32'h1111_2222, 1'b1}) begin
            errors++;
            $display("FAIL after_timeout: n=%0d rdata=%h err=%b required 2 11112222 1", n, dm_rdata, err);
        end
        dm_req = 0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_busy();
        int n;
        mem_hang = 1;
        dm_req = 1; dm_we = 0; dm_addr = 32'h400;
        repeat (3) @(negedge clk);
        checks++;
        if ({mem_req, err} !== 2'b11) begin
            errors++;
            $display("FAIL pre_reset_busy: mem_req=%b err=%b required 1 1", mem_req, err);
        end
        rst = 1;
        @(negedge clk);
        checks++;
        if ({mem_req, dm_done, if_done, err, dm_stall, dm_rdata} !== {5'b00001, 32'h0}) begin
            errors++;
            $display("FAIL reset_mid_busy: mem_req=%b done=%b if_done=%b err=%b stall=%b rdata=%h required 0 0 0 0 1 00000000",
                     mem_req, dm_done, if_done, err, dm_stall, dm_rdata);
        end
        rst = 0;
        mem_hang = 0; mem_lat = 0; mem_data = 32'h7777_8888;
        wait_done(1, 20, n);
        checks++;
        if ({n == 2, dm_rdata, err} !== {1'b1, 32'h7777_8888, 1'b0}) begin
            errors++;
            $display("FAIL regrant_after_reset: n=%0d rdata=%h err=%b required 2 77778888 0", n, dm_rdata, err);
        end
        dm_req = 0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_zero_wait_fetch();
        test_priority();
        test_store();
        test_timeout();
        test_reset_mid_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
